// File: rtl/sram_fifo_pkg.sv
// Shared defaults for the SRAM-backed FIFO controller.
//   DEF_DATA_WIDTH : word width of the freepdk45 1w1r macro
//   DEF_ADDR_WIDTH : macro address width
//   ptr_t          : SRAM pointer type for the default macro geometry
package sram_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 512;
  localparam int DEF_ADDR_WIDTH = 6;
  typedef logic [DEF_ADDR_WIDTH-1:0] ptr_t;
endpackage

// File: rtl/sram_rd_skid.sv
// Two-entry capture/output buffer behind the SRAM read port.
// Read data must be captured on the edge after the read, so push_i can
// never be refused; the controller only issues reads when a slot is free.
//   clk_i, rst_ni   : clock, async active-low reset
//   flush_i         : drop all entries (wins over push/pop)
//   push_i/data_i   : capture one word into the tail
//   pop_i           : head consumed (only asserted while valid_o)
//   valid_o/data_o  : registered head entry
//   cnt_o           : occupancy 0..2
module sram_rd_skid
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            cnt_o
);
  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d, eff;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    eff    = cnt_q - {1'b0, pop_i};
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      if (pop_i) head_d = tail_q;
      // Placement uses the post-pop occupancy so pop+push on a single
      // entry lands the new word directly in the head.
      if (push_i) begin
        if (eff == 2'd0) head_d = data_i;
        else             tail_d = data_i;
        cnt_d = eff + 2'd1;
      end else begin
        cnt_d = eff;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = head_q;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/sram_1w1r_fifo_ctrl.sv
// Streaming FIFO controller driving a 1w1r SRAM macro (both macro clocks
// tied to clk0). Upstream words are written straight into the macro; reads
// are issued whenever the output buffer is guaranteed room for the result.
//   clk0, rstb0          : clock, async active-low reset
//   flush                : synchronous discard of all contents
//   in_valid/ready/data  : upstream stream
//   out_valid/ready/data : downstream stream (registered)
//   count                : words held (SRAM + read in flight + buffer)
//   sram_csb0/addr0/din0 : macro write port
//   sram_csb1/addr1/dout1: macro read port
module sram_1w1r_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int CNT_WIDTH  = $clog2(DEPTH+2)+1
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic                  rd_pend_q;
  logic [1:0]            buf_cnt;
  logic                  pop, wr_en, rd_go, room;

  assign pop      = out_valid & out_ready;
  assign in_ready = rstb0 & (mem_cnt_q < DEPTH_C) & ~flush;
  assign wr_en    = in_valid & in_ready;

  // Buffer slots still free once the in-flight read lands and this cycle's
  // pop retires: buf_cnt + rd_pend - pop < 2.
  assign room  = ({1'b0, buf_cnt} + {2'b00, rd_pend_q}) < (3'd2 + {2'b00, pop});
  // mem_cnt is the start-of-cycle value, so a word written this cycle is
  // never read back in the same cycle and the two addresses always differ.
  assign rd_go = rstb0 & (mem_cnt_q != '0) & room & ~flush;

  assign sram_csb0  = ~wr_en;
  assign sram_addr0 = wr_ptr_q;
  assign sram_din0  = in_data;
  assign sram_csb1  = ~rd_go;
  assign sram_addr1 = rd_ptr_q;

  always_comb begin
    mem_cnt_d = mem_cnt_q;
    case ({wr_en, rd_go})
      2'b10:   mem_cnt_d = mem_cnt_q + 1'b1;
      2'b01:   mem_cnt_d = mem_cnt_q - 1'b1;
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      rd_pend_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, wr_en};
      rd_ptr_q  <= rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, rd_go};
      mem_cnt_q <= mem_cnt_d;
      rd_pend_q <= rd_go;
    end
  end

  // Macro output is only valid until T_HOLD after the next edge, so the
  // word read last cycle is captured unconditionally (unless flushed).
  sram_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk_i   (clk0),
    .rst_ni  (rstb0),
    .flush_i (flush),
    .push_i  (rd_pend_q & ~flush),
    .data_i  (sram_dout1),
    .pop_i   (pop),
    .valid_o (out_valid),
    .data_o  (out_data),
    .cnt_o   (buf_cnt)
  );

  assign count = CNT_WIDTH'(mem_cnt_q) + CNT_WIDTH'(rd_pend_q) + CNT_WIDTH'(buf_cnt);
endmodule

// File: tb/tb_sram_1w1r_fifo_ctrl.sv
module tb_sram_1w1r_fifo_ctrl;
  localparam int DW = 512;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam int CW = $clog2(DEPTH+2)+1;
  localparam logic [DW-1:0] POISON = {16{32'hDEADBEEF}};

  logic          clk0 = 1'b0;
  logic          rstb0, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data, sram_din0, sram_dout1;
  logic [CW-1:0] count;
  logic          sram_csb0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;

  always #5 clk0 = ~clk0;

  sram_1w1r_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk0(clk0), .rstb0(rstb0), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return {16{32'(i)}};
  endfunction

  // ---------------- SRAM macro model: write commits on negedge, read data
  // valid from hold time after the read edge until hold time after the next.
  logic [DW-1:0] mem [DEPTH];
  logic          wr_p, rd_p;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wd;
  initial begin
    foreach (mem[i]) mem[i] = POISON;
    sram_dout1 = POISON;
    wr_p = 1'b0;
  end
  always @(posedge clk0) begin
    wr_p = !sram_csb0; wa = sram_addr0; wd = sram_din0;
    rd_p = !sram_csb1; ra = sram_addr1;
    if (!sram_csb0 && !sram_csb1) chk("addr_collision", {31'b0, sram_addr0 == sram_addr1}, '0);
    #1;
    sram_dout1 = rd_p ? mem[ra] : POISON;
  end
  always @(negedge clk0) if (wr_p) begin mem[wa] = wd; wr_p = 1'b0; end

  // ---------------- behavioural model: ordered queue of accepted words and the
  // edge each was accepted at; the oldest word is visible two edges after it
  // entered, and count is simply the number of words held.
  logic [DW-1:0] mq[$];
  int            acc[$];
  int            cyc = 0;
  always @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      mq.delete(); acc.delete();
    end else begin
      cyc++;
      if (flush) begin
        mq.delete(); acc.delete();
      end else begin
        if (out_valid && out_ready && mq.size() > 0) begin
          void'(mq.pop_front()); void'(acc.pop_front());
        end
        if (in_valid && in_ready) begin
          mq.push_back(in_data); acc.push_back(cyc);
        end
      end
    end
  end

  always @(negedge clk0) begin
    if (rstb0) begin
      logic ev;
      ev = (mq.size() > 0) && (cyc - acc[0] >= 2);
      chk("m_out_valid", {511'b0, out_valid}, {511'b0, ev});
      if (ev) chk("m_out_data", out_data, mq[0]);
      chk("m_count", DW'(count), DW'(mq.size()));
      if (flush) chk("m_in_ready_flush", {511'b0, in_ready}, '0);
      else if (mq.size() < DEPTH) chk("m_in_ready_hi", {511'b0, in_ready}, 1);
      else if (mq.size() >= DEPTH+2) chk("m_in_ready_lo", {511'b0, in_ready}, '0);
    end
  end

  // ---------------- stimulus
  task automatic tick();
    @(posedge clk0); #1;
  endtask

  // mode 0: out_ready=0, 1: out_ready=1, 2: random
  task automatic push_n(input int n, input int start, input int mode, output int cycles);
    int i = 0;
    cycles = 0;
    while (i < n && cycles < 5000) begin
      in_valid = 1'b1;
      in_data  = word(start + i);
      out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      #1;
      if (in_ready) i++;
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    chk("push_n_done", DW'(i), DW'(n));
  endtask

  task automatic drain();
    int g = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    while (count != 0 && g < 500) begin tick(); g++; end
    tick();
    chk("drain_count", DW'(count), '0);
    chk("drain_valid", {511'b0, out_valid}, '0);
  endtask

  initial begin
    int cyc_used, i;
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc_used, i;
    rstb0 = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = word(7);
    #1;
    chk("rst_in_ready", {511'b0, in_ready}, '0);
    chk("rst_csb0", {511'b0, sram_csb0}, 1);
    chk("rst_csb1", {511'b0, sram_csb1}, 1);
    chk("rst_out_valid", {511'b0, out_valid}, '0);
    chk("rst_count", DW'(count), '0);
    tick(); tick();
    in_valid = 1'b0;
    rstb0 = 1'b1;
    tick();
    chk("post_rst_in_ready", {511'b0, in_ready}, 1);

    // single word latency
    in_valid = 1'b1; in_data = {128{4'hA, 4'h5}};
    #1;
    chk("sw_csb0", {511'b0, sram_csb0}, '0);
    chk("sw_addr0", DW'(sram_addr0), '0);
    chk("sw_din0", sram_din0, {128{8'hA5}});
    tick();
    in_valid = 1'b0;
    chk("sw_csb1", {511'b0, sram_csb1}, '0);
    chk("sw_addr1", DW'(sram_addr1), '0);
    chk("sw_count1", DW'(count), 1);
    tick();
    chk("sw_valid_e1", {511'b0, out_valid}, '0);
    tick();
    chk("sw_valid_e2", {511'b0, out_valid}, 1);
    chk("sw_data", out_data, {128{8'hA5}});
    drain();

    // streaming 200 words, full throughput, wraps the pointers
    push_n(200, 0, 1, cyc_used);
    chk("stream_cycles", DW'(cyc_used), DW'(200));
    drain();

    // fill until stall
    out_ready = 1'b0;
    i = 0;
    while (i < 100) begin
      in_valid = 1'b1; in_data = word(i);
      #1;
      if (!in_ready) break;
      tick();
      i++;
    end
    chk("fill_pushes", DW'(i), DW'(66));
    chk("fill_count", DW'(count), DW'(66));
    chk("fill_in_ready", {511'b0, in_ready}, '0);
    in_valid = 1'b0;
    chk("fill_head", out_data, word(0));
    drain();

    // backpressure
    push_n(500, 1000, 2, cyc_used);
    drain();

    // flush with a read in flight
    push_n(10, 2000, 0, cyc_used);
    tick(); tick(); tick();
    in_valid = 1'b1; in_data = word(2010); out_ready = 1'b1;
    tick();
    in_valid = 1'b1; in_data = word(2011); out_ready = 1'b0; flush = 1'b1;
    #1;
    chk("fl_count_pre", DW'(count), DW'(10));
    chk("fl_csb0", {511'b0, sram_csb0}, 1);
    chk("fl_csb1", {511'b0, sram_csb1}, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count", DW'(count), '0);
    chk("fl_valid", {511'b0, out_valid}, '0);
    in_valid = 1'b1; in_data = DW'(1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("fl_new_valid", {511'b0, out_valid}, 1);
    chk("fl_new_data", out_data, DW'(1));
    tick();
    chk("fl_no_stale", {511'b0, out_valid}, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
